current_state_mem: RTL and testbench
====================================

CURRENT_STATE_MEM -- requirements
Module: current_state_mem

Interface
REQ-001 SHALL have parameter width_p, default 16, meaning playfield width in cells.
REQ-002 SHALL have parameter height_p, default 32, meaning playfield height in cells.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port set_v_i, input, 1 bit: update request from an executor.
REQ-006 SHALL have port type_i, input, tile_type_e: new tile type.
REQ-007 SHALL have port angle_i, input, 2 bits: new tile angle.
REQ-008 SHALL have port pos_i, input, point_t: new base position (x_m, y_m).
REQ-009 SHALL have port ready_o, output, 1 bit: idle, state stable; drives executors' cm_is_ready_i.
REQ-010 SHALL have ports type_o (tile_type_e), angle_o (2 bits) and pos_o (point_t), all outputs: the stored current tile.
REQ-011 SHALL have port rom_addr_o, output, tile_type_e width + 2 bits: shape ROM address {type, angle}.
REQ-012 SHALL have port rom_data_i, input, 16 bits: cell k offset x at [4k+1:4k] and y at [4k+3:4k+2], k=0..3; valid one cycle after rom_addr_o.
REQ-013 SHALL have port mm_w_v_o, output, 1 bit: main-memory write strobe.
REQ-014 SHALL have port mm_w_x_o, output, $clog2(width_p) bits: write x coordinate.
REQ-015 SHALL have port mm_w_y_o, output, $clog2(height_p) bits: write y coordinate.
REQ-016 SHALL have port mm_w_data_o, output, 1 bit: 0 = erase cell, 1 = draw cell.

Function
REQ-017 SHALL implement FSM states eIDLE, eRomOld, eErase, eRomNew, eDraw, plus a 2-bit cell counter.
REQ-018 SHALL, in eIDLE on set_v_i, latch type_i/angle_i/pos_i as pending, then go to eRomOld if stored type != eNon, else to eRomNew.
REQ-019 SHALL ignore set_v_i in every state other than eIDLE.
REQ-020 SHALL drive ready_o = (state == eIDLE) from registered state, so ready_o is low the cycle after an accepted set_v_i.
REQ-021 SHALL drive rom_addr_o = {stored type, stored angle} in eRomOld/eErase, and {pending type, pending angle} in eRomNew/eDraw; 0 otherwise.
REQ-022 SHALL go from eRomOld to eErase after one cycle (ROM latency), and from eRomNew to eDraw after one cycle.
REQ-023 SHALL spend exactly 4 cycles in eErase and in eDraw, counter 0..3 selecting cell k; counter clears on entry.
REQ-024 SHALL, in eErase/eDraw, compute cell = base + offset_k in (width+1)/(height+1)-bit unsigned arithmetic, base being stored pos in eErase and pending pos in eDraw.
REQ-025 SHALL assert mm_w_v_o in eErase/eDraw only if x < width_p and y < height_p, otherwise suppress the write (no wrap-around).
REQ-026 SHALL drive mm_w_data_o = 0 in eErase and 1 in eDraw; all mm_w_* are 0 outside these states.
REQ-027 SHALL go eErase -> eRomNew after cell 3, and eDraw -> eIDLE after cell 3, copying pending into the stored tile on that final eDraw cycle.
REQ-028 SHALL keep type_o/angle_o/pos_o holding the old tile until the return to eIDLE.
REQ-029 SHALL have an accepted-update latency of 11 cycles to ready_o high, or 6 cycles if the stored type was eNon.
REQ-030 SHALL accept a set_v_i on the same cycle ready_o returns high.

Reset
REQ-031 SHALL, on reset_i, set state eIDLE, counter 0, stored and pending type eNon, angle 0, pos 0.
REQ-032 SHALL, on reset_i mid-sequence, abandon it with no further writes next cycle, and hold ready_o=1 and mm_w_v_o=0 from the cycle after reset.

Verification
REQ-033 SHALL cover: reset, then set_v_i with type T, angle 1, pos (3,5) -> erase skipped; 4 draw writes at (3,5)+offsets, data 1; ready_o high 6 cycles later; type_o=T, angle_o=1.
REQ-034 SHALL cover: stored tile valid, set_v_i with angle+1 -> 4 erase writes (data 0) at old cells, then 4 draw writes at new cells; ready_o low cycles 1-10, high at 11.
REQ-035 SHALL cover: pos (15,30) with offsets 1 on a 16x32 field -> writes with x>=16 or y>=32 are suppressed and the remaining writes occur normally.
REQ-036 SHALL cover: set_v_i pulsed during eErase -> ignored; stored tile equals the first request only.
REQ-037 SHALL cover: reset_i asserted in eDraw cell 1 -> no writes from the next cycle; ready_o=1; type_o=eNon.
REQ-038 SHALL cover: back-to-back updates, second set_v_i on the cycle ready_o rises -> accepted, full second sequence follows.

Source files
------------

// File: rtl/current_state_mem.sv
// Holds the current falling tile and, on an update, erases its old cells and
// draws the new ones into main memory using offsets read from the shape ROM.
module current_state_mem #(
  parameter int width_p = 16,
  parameter int height_p = 32,
  localparam int type_w = 3,
  localparam int x_w = $clog2(width_p),
  localparam int y_w = $clog2(height_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  set_v_i,
  input  logic [type_w-1:0]     type_i,
  input  logic [1:0]            angle_i,
  input  logic [x_w+y_w-1:0]    pos_i,
  output logic                  ready_o,
  output logic [type_w-1:0]     type_o,
  output logic [1:0]            angle_o,
  output logic [x_w+y_w-1:0]    pos_o,
  output logic [type_w+1:0]     rom_addr_o,
  input  logic [15:0]           rom_data_i,
  output logic                  mm_w_v_o,
  output logic [x_w-1:0]        mm_w_x_o,
  output logic [y_w-1:0]        mm_w_y_o,
  output logic                  mm_w_data_o,
  output logic [2:0]            state_o
);

  // Handshake: set_v_i is taken only in a cycle where ready_o is high; the
  // request needs no hold and is dropped silently in any other cycle.
  localparam logic [2:0] E_IDLE    = 3'd0;
  localparam logic [2:0] E_ROM_OLD = 3'd1;
  localparam logic [2:0] E_ERASE   = 3'd2;
  localparam logic [2:0] E_ROM_NEW = 3'd3;
  localparam logic [2:0] E_DRAW    = 3'd4;
  localparam logic [type_w-1:0] E_NON = '0;

  localparam logic [x_w:0] x_lim = width_p[x_w:0];
  localparam logic [y_w:0] y_lim = height_p[y_w:0];

  logic [2:0]          state;
  logic [1:0]          cnt;
  logic [type_w-1:0]   cur_type, pend_type;
  logic [1:0]          cur_angle, pend_angle;
  logic [x_w+y_w-1:0]  cur_pos, pend_pos;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= E_IDLE;
      cnt        <= 2'd0;
      cur_type   <= E_NON;
      cur_angle  <= 2'd0;
      cur_pos    <= '0;
      pend_type  <= E_NON;
      pend_angle <= 2'd0;
      pend_pos   <= '0;
    end else begin
      case (state)
        E_IDLE: begin
          if (set_v_i) begin
            pend_type  <= type_i;
            pend_angle <= angle_i;
            pend_pos   <= pos_i;
            state      <= (cur_type != E_NON) ? E_ROM_OLD : E_ROM_NEW;
          end
        end
        E_ROM_OLD: begin
          cnt   <= 2'd0;
          state <= E_ERASE;
        end
        E_ERASE: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= E_ROM_NEW;
        end
        E_ROM_NEW: begin
          cnt   <= 2'd0;
          state <= E_DRAW;
        end
        E_DRAW: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // The visible tile only changes once every new cell is drawn.
            cur_type  <= pend_type;
            cur_angle <= pend_angle;
            cur_pos   <= pend_pos;
            state     <= E_IDLE;
          end
        end
        default: state <= E_IDLE;
      endcase
    end
  end

  logic [1:0]     dx, dy;
  logic [x_w-1:0] base_x;
  logic [y_w-1:0] base_y;
  logic [x_w:0]   cell_x;
  logic [y_w:0]   cell_y;
  logic           in_write;

  always_comb begin
    dx       = rom_data_i[{cnt, 2'b00} +: 2];
    dy       = rom_data_i[{cnt, 2'b10} +: 2];
    in_write = (state == E_ERASE) || (state == E_DRAW);
    if (state == E_DRAW) begin
      base_x = pend_pos[x_w+y_w-1:y_w];
      base_y = pend_pos[y_w-1:0];
    end else begin
      base_x = cur_pos[x_w+y_w-1:y_w];
      base_y = cur_pos[y_w-1:0];
    end
    // One extra bit so cells past the right/bottom edge are detected, not wrapped.
    cell_x = {1'b0, base_x} + {{(x_w-1){1'b0}}, dx};
    cell_y = {1'b0, base_y} + {{(y_w-1){1'b0}}, dy};
  end

  always_comb begin
    rom_addr_o = '0;
    if (state == E_ROM_OLD || state == E_ERASE) rom_addr_o = {cur_type, cur_angle};
    else if (state == E_ROM_NEW || state == E_DRAW) rom_addr_o = {pend_type, pend_angle};
  end

  always_comb begin
    mm_w_v_o    = 1'b0;
    mm_w_x_o    = '0;
    mm_w_y_o    = '0;
    mm_w_data_o = 1'b0;
    if (in_write) begin
      mm_w_v_o    = (cell_x < x_lim) && (cell_y < y_lim);
      mm_w_x_o    = cell_x[x_w-1:0];
      mm_w_y_o    = cell_y[y_w-1:0];
      mm_w_data_o = (state == E_DRAW);
    end
  end

  assign ready_o = (state == E_IDLE);
  assign type_o  = cur_type;
  assign angle_o = cur_angle;
  assign pos_o   = cur_pos;
  assign state_o = state;

endmodule

// File: tb/tb_current_state_mem.sv
// Directed bench for current_state_mem: a table of tile updates with
// hand-computed cell writes and latencies, plus glitch and mid-draw reset cases.
module tb_current_state_mem;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        set_v_i;
  logic [2:0]  type_i;
  logic [1:0]  angle_i;
  logic [8:0]  pos_i;
  logic        ready_o;
  logic [2:0]  type_o;
  logic [1:0]  angle_o;
  logic [8:0]  pos_o;
  logic [4:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        mm_w_v_o;
  logic [3:0]  mm_w_x_o;
  logic [4:0]  mm_w_y_o;
  logic        mm_w_data_o;
  logic [2:0]  state_o;

  current_state_mem #(.width_p(16), .height_p(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .set_v_i(set_v_i), .type_i(type_i),
    .angle_i(angle_i), .pos_i(pos_i), .ready_o(ready_o), .type_o(type_o),
    .angle_o(angle_o), .pos_o(pos_o), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .mm_w_v_o(mm_w_v_o), .mm_w_x_o(mm_w_x_o),
    .mm_w_y_o(mm_w_y_o), .mm_w_data_o(mm_w_data_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // Shape ROM: nibble k = {dy, dx} of cell k, one cycle of latency.
  function automatic logic [15:0] rom_fn(input logic [4:0] addr);
    case (addr)
      {3'd1, 2'd0}: rom_fn = 16'h5210;
      {3'd1, 2'd1}: rom_fn = 16'h9541;
      {3'd1, 2'd2}: rom_fn = 16'h1654;
      {3'd1, 2'd3}: rom_fn = 16'h5840;
      {3'd2, 2'd0}, {3'd2, 2'd1}, {3'd2, 2'd2}, {3'd2, 2'd3}: rom_fn = 16'h5410;
      default: rom_fn = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_i) rom_data_i <= rom_fn(rom_addr_o);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected writes {data, x, y} in issue order
  logic [9:0] exp_q[$];

  always @(negedge clk_i) begin
    if (mm_w_v_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", {mm_w_data_o, mm_w_x_o, mm_w_y_o});
      end else begin
        chk("write", {22'd0, mm_w_data_o, mm_w_x_o, mm_w_y_o}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [2:0]       t;
    logic [1:0]       a;
    logic [3:0]       x;
    logic [4:0]       y;
    int               lat;
    int               glitch_at;
    int               reset_at;
    int               n_wr;
    logic [7:0][9:0]  wr;
  } vec_t;

  vec_t vecs[7];
  logic [2:0] cur_t;
  logic [1:0] cur_a;
  logic [8:0] cur_p;

  task automatic set_vec(input int i, input logic [2:0] t, input logic [1:0] a,
                         input logic [3:0] x, input logic [4:0] y, input int lat,
                         input int glitch_at, input int reset_at);
    vecs[i].t = t; vecs[i].a = a; vecs[i].x = x; vecs[i].y = y;
    vecs[i].lat = lat; vecs[i].glitch_at = glitch_at; vecs[i].reset_at = reset_at;
    vecs[i].n_wr = 0; vecs[i].wr = '0;
  endtask

  task automatic add_wr(input int i, input logic d, input logic [3:0] x, input logic [4:0] y);
    vecs[i].wr[vecs[i].n_wr] = {d, x, y};
    vecs[i].n_wr++;
  endtask

  // driver: issue one update and follow it to completion (or to a forced reset)
  task automatic run_vec(input vec_t v);
    int n;
    bool_reset: begin end
    for (int i = 0; i < v.n_wr; i++) exp_q.push_back(v.wr[i]);
    type_i = v.t; angle_i = v.a; pos_i = {v.x, v.y}; set_v_i = 1'b1;
    @(posedge clk_i); #1;
    set_v_i = 1'b0;
    n = 1;
    chk("ready_low_after_accept", {31'd0, ready_o}, 32'd0);
    while (!ready_o && n < 40) begin
      if (n == v.glitch_at) begin
        set_v_i = 1'b1; type_i = 3'd1; angle_i = 2'd3; pos_i = {4'd8, 5'd8};
      end
      if (n == 5) begin
        chk("old_type_held", {29'd0, type_o}, {29'd0, cur_t});
        chk("old_pos_held", {23'd0, pos_o}, {23'd0, cur_p});
      end
      if (n == v.reset_at) reset_i = 1'b1;
      @(posedge clk_i); #1;
      set_v_i = 1'b0;
      n++;
      if (reset_i) begin
        reset_i = 1'b0;
        chk("ready_after_reset", {31'd0, ready_o}, 32'd1);
        chk("no_write_after_reset", {31'd0, mm_w_v_o}, 32'd0);
        chk("type_after_reset", {29'd0, type_o}, 32'd0);
        chk("pos_after_reset", {23'd0, pos_o}, 32'd0);
        cur_t = 3'd0; cur_a = 2'd0; cur_p = 9'd0;
        @(posedge clk_i); #1;
        chk("still_idle_after_reset", {31'd0, ready_o}, 32'd1);
        chk("expected_writes_drained", exp_q.size(), 32'd0);
        return;
      end
    end
    chk("latency", n, v.lat);
    chk("type_o", {29'd0, type_o}, {29'd0, v.t});
    chk("angle_o", {30'd0, angle_o}, {30'd0, v.a});
    chk("pos_o", {23'd0, pos_o}, {23'd0, v.x, v.y});
    chk("expected_writes_drained", exp_q.size(), 32'd0);
    cur_t = v.t; cur_a = v.a; cur_p = {v.x, v.y};
  endtask

  initial begin
    // first placement after reset: no erase
    set_vec(0, 3'd1, 2'd1, 4'd3, 5'd5, 6, 0, 0);
    add_wr(0, 1, 4, 5); add_wr(0, 1, 3, 6); add_wr(0, 1, 4, 6); add_wr(0, 1, 4, 7);
    // rotate in place
    set_vec(1, 3'd1, 2'd2, 4'd3, 5'd5, 11, 0, 0);
    add_wr(1, 0, 4, 5); add_wr(1, 0, 3, 6); add_wr(1, 0, 4, 6); add_wr(1, 0, 4, 7);
    add_wr(1, 1, 3, 6); add_wr(1, 1, 4, 6); add_wr(1, 1, 5, 6); add_wr(1, 1, 4, 5);
    // move to the field corner: right column of the square is clipped
    set_vec(2, 3'd2, 2'd0, 4'd15, 5'd30, 11, 0, 0);
    add_wr(2, 0, 3, 6); add_wr(2, 0, 4, 6); add_wr(2, 0, 5, 6); add_wr(2, 0, 4, 5);
    add_wr(2, 1, 15, 30); add_wr(2, 1, 15, 31);
    // clipped in x and y
    set_vec(3, 3'd1, 2'd1, 4'd15, 5'd30, 11, 0, 0);
    add_wr(3, 0, 15, 30); add_wr(3, 0, 15, 31);
    add_wr(3, 1, 15, 31);
    // second request pulsed during erase is dropped
    set_vec(4, 3'd2, 2'd0, 4'd2, 5'd2, 11, 3, 0);
    add_wr(4, 0, 15, 31);
    add_wr(4, 1, 2, 2); add_wr(4, 1, 3, 2); add_wr(4, 1, 2, 3); add_wr(4, 1, 3, 3);
    // reset during draw cell 1
    set_vec(5, 3'd1, 2'd0, 4'd6, 5'd6, 0, 0, 8);
    add_wr(5, 0, 2, 2); add_wr(5, 0, 3, 2); add_wr(5, 0, 2, 3); add_wr(5, 0, 3, 3);
    add_wr(5, 1, 6, 6); add_wr(5, 1, 7, 6);
    // recovery after reset: empty stored tile again
    set_vec(6, 3'd2, 2'd0, 4'd0, 5'd0, 6, 0, 0);
    add_wr(6, 1, 0, 0); add_wr(6, 1, 1, 0); add_wr(6, 1, 0, 1); add_wr(6, 1, 1, 1);

    reset_i = 1'b1; set_v_i = 1'b0; type_i = 3'd0; angle_i = 2'd0; pos_i = 9'd0;
    cur_t = 3'd0; cur_a = 2'd0; cur_p = 9'd0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_type", {29'd0, type_o}, 32'd0);
    chk("reset_angle", {30'd0, angle_o}, 32'd0);
    chk("reset_pos", {23'd0, pos_o}, 32'd0);
    chk("reset_wv", {31'd0, mm_w_v_o}, 32'd0);
    chk("reset_rom_addr", {27'd0, rom_addr_o}, 32'd0);
    chk("reset_state", {29'd0, state_o}, 32'd0);

    // updates are issued back to back: each starts in the cycle ready_o rises
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
